// File: rtl/bist_ora_pkg.sv
// -----------------------------------------------------------------------------
// bist_ora_pkg
// Shared definitions for the BIST output-response analyser:
//   - ora_state_t   : session state encoding (IDLE, COLLECT, CHECK, DONE)
//   - DEF_POLY      : default MISR feedback taps, x^32+x^22+x^2+x+1
//   - DEF_SEED      : default signature seed
//   - MISR_MAX_W    : widest signature misr_step can handle
//   - misr_step()   : one MISR compaction step for any width up to MISR_MAX_W
// -----------------------------------------------------------------------------
package bist_ora_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_CHECK   = 2'd2,
        S_DONE    = 2'd3
    } ora_state_t;

    localparam logic [31:0] DEF_POLY   = 32'h0040_0007;
    localparam logic [31:0] DEF_SEED   = 32'h0000_0001;
    localparam int          MISR_MAX_W = 64;

    // Operands are zero-extended to MISR_MAX_W; width selects the live
    // signature slice. The feedback bit is the MSB of the live slice, and
    // everything above the slice is masked off so callers can truncate freely.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] stim,
        input logic [MISR_MAX_W-1:0] poly,
        input int                    width
    );
        logic [MISR_MAX_W-1:0] x;
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] msb_sel;
        logic                  fb;
        x       = sig ^ stim;
        msb_sel = MISR_MAX_W'(1) << (width - 1);
        fb      = |(x & msb_sel);
        mask    = (width >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << width) - 1'b1);
        return ((x << 1) ^ (fb ? poly : '0)) & mask;
    endfunction

endpackage

// File: rtl/ora_misr_core.sv
// -----------------------------------------------------------------------------
// ora_misr_core
// Signature register of the output-response analyser. Reset and load_seed
// both place SEED in the register; step compacts one stimulus word.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (loads SEED)
//   load_seed  in   reload SEED (session start); wins over step
//   step       in   compact stim into the signature this cycle
//   stim       in   WIDTH  zero-extended sample word
//   sig        out  WIDTH  current signature
// -----------------------------------------------------------------------------
module ora_misr_core
    import bist_ora_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_seed,
    input  logic             step,
    input  logic [WIDTH-1:0] stim,
    output logic [WIDTH-1:0] sig
);

    if (WIDTH > MISR_MAX_W || WIDTH < 2) begin : g_bad_width
        $error("ora_misr_core: WIDTH must be in 2..MISR_MAX_W");
    end

    always_ff @(posedge clk) begin
        if (rst || load_seed) begin
            sig <= SEED;
        end else if (step) begin
            sig <= WIDTH'(misr_step(MISR_MAX_W'(sig), MISR_MAX_W'(stim),
                                    MISR_MAX_W'(POLY), WIDTH));
        end
    end

endmodule

// File: rtl/bist_ora_misr.sv
// -----------------------------------------------------------------------------
// bist_ora_misr
// BIST output-response analyser for the data-memory write port. Compacts a
// bounded session of {address, data} write samples into a MISR signature
// starting from SEED, then compares against a golden value.
//
// Optional feature macro: BIST_ORA_GOLDEN_CMP_EN
//   defined   : golden is latched at start and pass/fail come from the compare
//   undefined : golden is ignored and pass/fail stay 0; CHECK still takes one
//               cycle so done timing is identical in both builds
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   single-cycle session start (IDLE or DONE)
//   abort       in   cancel session (COLLECT/CHECK/DONE); beats start
//   sample_len  in   CNT_W   samples to compact, latched at start
//   golden      in   WIDTH   expected signature, latched at start
//   smp_valid   in   sample qualifier (memory write enable)
//   smp_addr    in   ADDR_W  sample address (upper part of stimulus)
//   smp_data    in   DATA_W  sample data (lower part of stimulus)
//   busy        out  high in COLLECT and CHECK
//   done        out  high in DONE
//   signature   out  WIDTH   current MISR value
//   smp_count   out  CNT_W   samples compacted this session
//   pass        out  signature matched golden (valid with done)
//   fail        out  signature differed from golden (valid with done)
// -----------------------------------------------------------------------------
module bist_ora_misr
    import bist_ora_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(DEF_SEED),
    parameter int               ADDR_W = 16,
    parameter int               DATA_W = 16,
    parameter int               CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  sample_len,
    input  logic [WIDTH-1:0]  golden,
    input  logic              smp_valid,
    input  logic [ADDR_W-1:0] smp_addr,
    input  logic [DATA_W-1:0] smp_data,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  signature,
    output logic [CNT_W-1:0]  smp_count,
    output logic              pass,
    output logic              fail
);

    if (ADDR_W + DATA_W > WIDTH) begin : g_bad_cfg
        $error("bist_ora_misr: ADDR_W+DATA_W must not exceed WIDTH");
    end

    ora_state_t        state;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [WIDTH-1:0]  stim;
    logic              load_seed;
    logic              step;

`ifdef BIST_ORA_GOLDEN_CMP_EN
    logic [WIDTH-1:0]  golden_q;
`else
    logic              golden_unused;
    assign golden_unused = ^golden;
`endif

    assign stim    = WIDTH'({smp_addr, smp_data});
    assign cnt_inc = smp_count + 1'b1;

    // Seed reload happens on any accepted start; in DONE an abort suppresses
    // it, in IDLE abort is meaningless so start is always honoured.
    assign load_seed = start && ((state == S_IDLE) || (state == S_DONE && !abort));
    assign step      = (state == S_COLLECT) && smp_valid && !abort;

    ora_misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load_seed (load_seed),
        .step      (step),
        .stim      (stim),
        .sig       (signature)
    );

    // Session FSM with registered status outputs; busy/done are written on
    // the same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            smp_count <= '0;
            len_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
`ifdef BIST_ORA_GOLDEN_CMP_EN
            golden_q  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_DONE && abort) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                        fail  <= 1'b0;
                    end else if (start) begin
                        smp_count <= '0;
                        len_q     <= sample_len;
`ifdef BIST_ORA_GOLDEN_CMP_EN
                        golden_q  <= golden;
`endif
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        state     <= (sample_len == '0) ? S_CHECK : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (smp_valid) begin
                        smp_count <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    busy <= 1'b0;
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
`ifdef BIST_ORA_GOLDEN_CMP_EN
                        pass  <= (signature == golden_q);
                        fail  <= (signature != golden_q);
`else
                        pass  <= 1'b0;
                        fail  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bist_ora_misr.md
# bist_ora_misr

Parametrised BIST output-response analyser for the MIPS-16 memory path. It compacts a bounded session of write-address/data samples into a configurable-width MISR signature, starting from a programmable seed. At session end it compares the signature against a golden value and reports pass/fail. It sits beside the data-memory write port in the BIST wrapper and is controlled by the BIST sequencer.

## Interface
- WIDTH, 32: signature width; ADDR_W+DATA_W ≤ WIDTH
- POLY, 32'h0040_0007: feedback taps (x^32+x^22+x^2+x+1), bit i = tap into bit i
- SEED, 1: signature value loaded at reset and at each start
- ADDR_W, 16: sample address width
- DATA_W, 16: sample data width
- CNT_W, 16: sample counter width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle session start
- abort  in  1  cancel active session
- sample_len  in  CNT_W  samples to compact; latched at start
- golden  in  WIDTH  expected signature; latched at start
- smp_valid  in  1  sample qualifier (memory write enable)
- smp_addr  in  ADDR_W  sample address
- smp_data  in  DATA_W  sample data
- busy  out  1  high in COLLECT and CHECK
- done  out  1  high in DONE
- signature  out  WIDTH  current MISR register
- smp_count  out  CNT_W  samples compacted this session
- pass  out  1  signature == golden (valid when done)
- fail  out  1  signature != golden (valid when done)

## Operation
- Stimulus: s = zero-extended {smp_addr, smp_data}; address occupies the upper bits.
- Step: x = sig ^ s; sig_next = {x[WIDTH-2:0],1'b0} ^ (x[WIDTH-1] ? POLY : 0).
- States: IDLE, COLLECT, CHECK, DONE.
- IDLE: signature holds. start loads sig=SEED, count=0, and latches sample_len and golden. Next state is COLLECT, or CHECK if sample_len==0.
- COLLECT: each smp_valid performs one step and count+1. No step occurs without smp_valid. The sample taking count to sample_len moves the block to CHECK. start is ignored.
- CHECK: one cycle; registers pass/fail from the compare; moves to DONE.
- DONE: done, pass and fail hold. start begins a new session with the same actions as in IDLE. Samples are ignored.
- abort in COLLECT, CHECK or DONE: go to IDLE and clear done, pass and fail. signature and smp_count keep their values. abort takes priority over start. In IDLE abort has no effect and start is taken.
- Counter does not wrap: sample_len = 2^CNT_W−1 is the maximum.
- rst in any state: IDLE, sig=SEED, count=0, latches cleared.

## Timing
- Reset values: busy=0, done=0, pass=0, fail=0, signature=SEED, smp_count=0.
- All outputs are registered. A sample accepted at edge k appears on signature after edge k.
- Last sample at edge k: CHECK after edge k; done, pass and fail valid after edge k+1.
- start at edge k: busy=1 after edge k. For sample_len=0: done after edge k+1.
- Throughput is one sample per cycle with no back-pressure.

## Configuration
- BIST_ORA_GOLDEN_CMP_EN defined: golden latch, comparator and pass/fail are built as described above.
- Macro not defined: golden is unused, and pass and fail are tied 0. CHECK still lasts one cycle, so done timing does not change.

## Structure
- Package bist_ora_pkg holds:
  - the state enum
  - default POLY and SEED constants
  - the misr_step function (WIDTH-generic via parameters)
- Sub-module ora_misr_core holds the signature register with load-seed and step controls. The FSM, counter and compare stay in bist_ora_misr.
- Elaboration assertion: ADDR_W+DATA_W ≤ WIDTH.

## Test plan
- Reset, then start with sample_len=1 and one sample addr=0x0000, data=0x0000 -> signature=0x00000002, done after 2 further edges.
- sample_len=1, addr=0x8000, data=0x0000 -> signature=0x00400005. With golden=0x00400005: pass=1, fail=0. With golden=0: fail=1.
- sample_len=3 with smp_valid gaps between samples -> signature only changes on valid cycles; smp_count steps 1,2,3; busy stays high throughout the gaps.
- sample_len=0 -> CHECK on the next edge; signature=SEED=1; pass=1 if golden=1.
- abort mid-COLLECT after 2 of 5 samples, asserted together with start -> IDLE, done=0, smp_count=2, signature retained; a later start reloads SEED.
- Synchronous rst asserted in DONE -> all outputs at reset values on the next edge; start during COLLECT has no effect.
